// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-bus target.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        IGNORE
    } i2c_state_t;

    localparam logic I2C_ACK       = 1'b0;
    localparam logic I2C_NACK      = 1'b1;
    localparam int   BITS_PER_BYTE = 8;

    function automatic int ptr_bytes(input int addr_w);
        return addr_w / BITS_PER_BYTE;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser and edge detector for one I2C line.
// Define I2C_GLITCH_FILTER_EN to require 3 equal samples before a level change is accepted.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;

    // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= line_in;
            sync <= meta;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] stable_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level      <= 1'b1;
            rise       <= 1'b0;
            fall       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == 2'd2) begin
                level      <= sync;
                rise       <= sync;
                fall       <= ~sync;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 2'd1;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            level <= sync;
            rise  <= sync & ~level;
            fall  <= ~sync & level;
        end
    end
`endif

endmodule

// File: rtl/i2c_reg_peripheral.sv
// I2C target that bridges bus writes/reads onto a we/re register strobe interface.
// Optional input glitch filter is enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_reg_peripheral
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    localparam int PTR_BYTES = ptr_bytes(ADDR_W);

    i2c_state_t        state, state_next;
    logic              scl_lvl, scl_rise, scl_fall;
    logic              sda_lvl, sda_rise, sda_fall;
    logic              start_evt, stop_evt;
    logic [7:0]        shreg, byte_next;
    logic [3:0]        bit_cnt;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] ptr, ptr_acc, acc_next;
    logic              rw, rd_load, addr_match, byte_done, ack_done;

    i2c_line_sync u_scl_sync (.clk(clk), .rst(rst), .line_in(scl),
                              .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    i2c_line_sync u_sda_sync (.clk(clk), .rst(rst), .line_in(sda_in),
                              .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

    assign start_evt  = scl_lvl & sda_fall;
    assign stop_evt   = scl_lvl & sda_rise;
    assign byte_next  = {shreg[6:0], sda_lvl};
    assign addr_match = (byte_next[7:1] == DEV_ADDR);
    assign acc_next   = ADDR_W'({ptr_acc, byte_next});
    assign byte_done  = scl_rise && (bit_cnt == 4'd7);
    // In ACK states bit_cnt[0] marks that SDA is already being held low.
    assign ack_done   = scl_fall && bit_cnt[0];
    assign reg_addr   = ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start_evt) begin
            state_next = DEV;
        end else if (stop_evt) begin
            state_next = IDLE;
        end else begin
            case (state)
                DEV:       if (byte_done) state_next = addr_match ? DEV_ACK : IGNORE;
                PTR:       if (byte_done) state_next = PTR_ACK;
                WDATA:     if (byte_done) state_next = WDATA_ACK;
                DEV_ACK:   if (ack_done) state_next = rw ? RDATA : PTR;
                PTR_ACK:   if (ack_done) state_next = (byte_cnt == 2'(PTR_BYTES)) ? WDATA : PTR;
                WDATA_ACK: if (ack_done) state_next = WDATA;
                RDATA:     if (scl_fall && bit_cnt == 4'd8) state_next = RACK;
                RACK:      if (scl_rise) state_next = (sda_lvl == I2C_ACK) ? RDATA : IGNORE;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_oe    <= 1'b0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            ptr       <= '0;
            ptr_acc   <= '0;
            reg_wdata <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            rw        <= 1'b0;
            rd_load   <= 1'b0;
        end else begin
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            rd_load <= reg_re;
            if (start_evt) begin
                sda_oe   <= 1'b0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (stop_evt) begin
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    DEV, PTR, WDATA: if (scl_rise) begin
                        shreg   <= byte_next;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if (state == DEV) begin
                                rw     <= sda_lvl;
                                busy   <= addr_match;
                                reg_re <= addr_match & sda_lvl;
                            end else if (state == PTR) begin
                                ptr_acc  <= acc_next;
                                byte_cnt <= byte_cnt + 2'd1;
                                if (byte_cnt == 2'(PTR_BYTES - 1)) ptr <= acc_next;
                            end else begin
                                reg_we    <= 1'b1;
                                reg_wdata <= byte_next;
                            end
                        end
                    end
                    DEV_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!bit_cnt[0]) begin
                            sda_oe  <= 1'b1;
                            bit_cnt <= 4'd1;
                        end else begin
                            bit_cnt <= '0;
                            // A read drives its first data bit on the same fall that ends the ACK.
                            sda_oe  <= (state == DEV_ACK && rw) ? ~shreg[7] : 1'b0;
                            if (state == WDATA_ACK) ptr <= ptr + ADDR_W'(1);
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                            end else begin
                                sda_oe <= ~shreg[3'd7 - bit_cnt[2:0]];
                            end
                        end
                    end
                    RACK: if (scl_rise && sda_lvl == I2C_ACK) begin
                        ptr    <= ptr + ADDR_W'(1);
                        reg_re <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (rd_load) shreg <= reg_rdata;
        end
    end

endmodule

// File: tb/tb_i2c_reg_peripheral.sv
// Bench: a bit-banged I2C master drives two targets (8-bit and 16-bit pointer) on one bus,
// checked against a transaction-level register model.
module tb_i2c_reg_peripheral;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_bus;
    logic        sda_oe0, sda_oe1, we0, we1, re0, re1, busy0, busy1;
    logic [7:0]  reg_addr0, wdata0, wdata1;
    logic [15:0] reg_addr1;
    logic [7:0]  rdata0 = 8'h00;
    logic [7:0]  rdata1 = 8'h00;

    int n_checks = 0;
    int n_errors = 0;
    int oe_cycles = 0;
    int both_cnt = 0;
    int start_cnt = 0;

    logic [24:0] we_q[$];
    logic [16:0] re_q[$];
    logic [7:0]  rf[int];
    logic [7:0]  model[int];
    logic [7:0]  wbuf[8];

    assign sda_bus = m_sda & ~sda_oe0 & ~sda_oe1;

    always #5 clk = ~clk;

    i2c_reg_peripheral #(.DEV_ADDR(7'h42), .ADDR_W(8)) dut0 (
        .clk(clk), .rst(rst), .scl(m_scl), .sda_in(sda_bus), .sda_oe(sda_oe0),
        .reg_addr(reg_addr0), .reg_wdata(wdata0), .reg_we(we0), .reg_re(re0),
        .reg_rdata(rdata0), .busy(busy0));

    i2c_reg_peripheral #(.DEV_ADDR(7'h50), .ADDR_W(16)) dut1 (
        .clk(clk), .rst(rst), .scl(m_scl), .sda_in(sda_bus), .sda_oe(sda_oe1),
        .reg_addr(reg_addr1), .reg_wdata(wdata1), .reg_we(we1), .reg_re(re1),
        .reg_rdata(rdata1), .busy(busy1));

    // Power-up contents of the register files.
    function automatic logic [7:0] init_val(input int key);
        return 8'(key * 73 + 29) ^ 8'(key >>> 8);
    endfunction

    function automatic logic [7:0] rf_rd(input int key);
        return rf.exists(key) ? rf[key] : init_val(key);
    endfunction

    function automatic logic [7:0] model_rd(input int key);
        return model.exists(key) ? model[key] : init_val(key);
    endfunction

    function automatic int dev_of(input logic [6:0] a7);
        return (a7 == 7'h42) ? 0 : (a7 == 7'h50) ? 1 : -1;
    endfunction

    always @(posedge clk) begin
        if (re0) rdata0 <= rf_rd(int'(reg_addr0));
        if (re1) rdata1 <= rf_rd(65536 + int'(reg_addr1));
        if (we0) begin
            rf[int'(reg_addr0)] = wdata0;
            we_q.push_back({1'b0, 8'h00, reg_addr0, wdata0});
        end
        if (we1) begin
            rf[65536 + int'(reg_addr1)] = wdata1;
            we_q.push_back({1'b1, reg_addr1, wdata1});
        end
        if (re0) re_q.push_back({1'b0, 8'h00, reg_addr0});
        if (re1) re_q.push_back({1'b1, reg_addr1});
        if (sda_oe0 | sda_oe1) oe_cycles++;
        if ((we0 && re0) || (we1 && re1)) both_cnt++;
    end

`ifdef I2C_GLITCH_FILTER_EN
    always @(posedge clk) if (dut0.start_evt) start_cnt++;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q();
        r = sda_bus;  wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic xfer_byte(input logic [7:0] tx, input logic ack_in,
                             output logic [7:0] rx, output logic ack_out);
        logic b;
        rx = '0;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(tx[i], b);
            rx[i] = b;
        end
        xfer_bit(ack_in, ack_out);
    endtask

    task automatic send_hdr(input logic [6:0] a7, input logic rw, input int dev);
        logic [7:0] rx;
        logic ak;
        i2c_start();
        xfer_byte({a7, rw}, 1'b1, rx, ak);
        check("addr ack", 32'(ak), 32'(dev < 0));
        check("busy after addr", 32'(busy0 | busy1), 32'(dev >= 0));
    endtask

    task automatic send_ptr(input int dev, input logic [15:0] ptr);
        logic [7:0] rx;
        logic ak;
        for (int b = (dev == 1 ? 1 : 0); b >= 0; b--) begin
            xfer_byte(ptr[8*b +: 8], 1'b1, rx, ak);
            check("ptr ack", 32'(ak), 32'(dev < 0));
        end
    endtask

    task automatic pop_re(input int dev, input logic [15:0] a);
        check("re count", 32'(re_q.size()), 32'd1);
        if (re_q.size() > 0) check("re addr", 32'(re_q.pop_front()), 32'({dev[0], a}));
    endtask

    task automatic do_write(input logic [6:0] a7, input logic [15:0] ptr, input int n);
        int dev, oe0;
        logic [15:0] mask, a;
        logic [7:0] rx;
        logic ak;
        dev  = dev_of(a7);
        oe0  = oe_cycles;
        mask = (dev == 1) ? 16'hFFFF : 16'h00FF;
        send_hdr(a7, 1'b0, dev);
        send_ptr(dev, ptr);
        for (int i = 0; i < n; i++) begin
            a = (ptr + 16'(i)) & mask;
            xfer_byte(wbuf[i], 1'b1, rx, ak);
            check("data ack", 32'(ak), 32'(dev < 0));
            if (dev >= 0) begin
                model[dev * 65536 + int'(a)] = wbuf[i];
                check("we count", 32'(we_q.size()), 32'd1);
                if (we_q.size() > 0) check("we event", 32'(we_q.pop_front()), 32'({dev[0], a, wbuf[i]}));
            end
        end
        i2c_stop();
        check("busy after stop", 32'(busy0 | busy1), 32'd0);
        check("stray we", 32'(we_q.size()), 32'd0);
        if (dev < 0) check("sda driven on mismatch", 32'(oe_cycles - oe0), 32'd0);
    endtask

    task automatic do_read(input logic [6:0] a7, input logic [15:0] ptr, input int n);
        int dev, oe0;
        logic [15:0] mask, a;
        logic [7:0] rx;
        logic ak;
        dev  = dev_of(a7);
        oe0  = oe_cycles;
        mask = (dev == 1) ? 16'hFFFF : 16'h00FF;
        send_hdr(a7, 1'b0, dev);
        send_ptr(dev, ptr);
        send_hdr(a7, 1'b1, dev);
        if (dev >= 0) pop_re(dev, ptr & mask);
        for (int i = 0; i < n; i++) begin
            a = (ptr + 16'(i)) & mask;
            xfer_byte(8'hFF, (i == n - 1), rx, ak);
            check("read data", 32'(rx), (dev < 0) ? 32'hFF : 32'(model_rd(dev * 65536 + int'(a))));
            if (dev >= 0 && i < n - 1) pop_re(dev, (a + 16'd1) & mask);
        end
        i2c_stop();
        check("busy after stop", 32'(busy0 | busy1), 32'd0);
        check("stray re", 32'(re_q.size()), 32'd0);
        if (dev < 0) check("sda driven on mismatch", 32'(oe_cycles - oe0), 32'd0);
    endtask

    initial begin
        repeat (1500000) @(posedge clk);
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int sel, n, s0;
        logic [6:0]  a7;
        logic [15:0] ptr;
        logic [7:0]  rx;
        logic        b;

        repeat (3) @(posedge clk);
        #1;
        check("rst sda_oe0", 32'(sda_oe0), 32'd0);
        check("rst sda_oe1", 32'(sda_oe1), 32'd0);
        check("rst we/re", 32'({we0, re0, we1, re1}), 32'd0);
        check("rst busy", 32'({busy0, busy1}), 32'd0);
        check("rst reg_addr0", 32'(reg_addr0), 32'd0);
        check("rst reg_addr1", 32'(reg_addr1), 32'd0);
        check("rst reg_wdata", 32'({wdata0, wdata1}), 32'd0);
        rst = 1'b0;
        wait_q();

`ifdef I2C_GLITCH_FILTER_EN
        s0 = start_cnt;
        m_sda = 1'b0; repeat (2) @(posedge clk); #1;
        m_sda = 1'b1; wait_q();
        check("2-clk glitch rejected", 32'(start_cnt - s0), 32'd0);
        s0 = start_cnt;
        m_sda = 1'b0; repeat (4) @(posedge clk); #1;
        m_sda = 1'b1; wait_q();
        check("4-clk glitch seen", 32'(start_cnt - s0), 32'd1);
`endif

        wbuf[0] = 8'h66;
        do_write(7'h42, 16'h0067, 1);
        do_read(7'h42, 16'h0067, 1);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(7'h42, 16'h00FE, 3);

        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        do_write(7'h43, 16'h0010, 2);

        // STOP in the middle of a data byte
        send_hdr(7'h42, 1'b0, 0);
        send_ptr(0, 16'h0010);
        for (int i = 0; i < 4; i++) xfer_bit(1'b0, b);
        i2c_stop();
        check("partial byte we", 32'(we_q.size()), 32'd0);
        check("partial byte busy", 32'(busy0), 32'd0);
        check("partial byte sda", 32'(sda_oe0), 32'd0);

        wbuf[0] = 8'hAB;
        do_write(7'h50, 16'h1234, 1);
        wbuf[0] = 8'h01; wbuf[1] = 8'h02;
        do_write(7'h50, 16'hFFFF, 2);
        do_read(7'h50, 16'h1233, 3);
        do_read(7'h42, 16'h00FE, 4);

        // Reset while the target is driving a zero read bit
        wbuf[0] = 8'h00;
        do_write(7'h42, 16'h0020, 1);
        send_hdr(7'h42, 1'b0, 0);
        send_ptr(0, 16'h0020);
        send_hdr(7'h42, 1'b1, 0);
        pop_re(0, 16'h0020);
        for (int i = 0; i < 3; i++) xfer_bit(1'b1, b);
        check("rd bit driven low", 32'(sda_oe0), 32'd1);
        #2 rst = 1'b1;
        #1 check("rst releases sda", 32'(sda_oe0), 32'd0);
        check("rst clears busy", 32'(busy0), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        i2c_stop();
        check("rst reg_addr mid", 32'(reg_addr0), 32'd0);

        for (int t = 0; t < 10; t++) begin
            sel = $urandom_range(0, 2);
            a7  = (sel == 0) ? 7'h42 : (sel == 1) ? 7'h50 : 7'h43;
            ptr = 16'($urandom);
            n   = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a7, ptr, n);
            else                           do_read(a7, ptr, n);
        end

        check("we and re together", 32'(both_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
